// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: issues one req/gnt/rvalid bus transaction per memory op,
// stalls the pipeline until it completes and aligns/extends load data for write-back.
module mem_lsu #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    mem_aluop_i,
  input  logic [31:0]   mem_addr_i,
  input  logic [31:0]   mem_reg2_i,
  input  logic [4:0]    wd_i,
  input  logic          wreg_i,
  input  logic [31:0]   wdata_i,
  output logic [4:0]    wd_o,
  output logic          wreg_o,
  output logic [31:0]   wdata_o,
  output logic          stall_req_o,
  output logic          misalign_o,
  output logic          dbus_req_o,
  output logic          dbus_we_o,
  output logic [3:0]    dbus_be_o,
  output logic [AW-1:0] dbus_addr_o,
  output logic [DW-1:0] dbus_wdata_o,
  input  logic          dbus_gnt_i,
  input  logic [DW-1:0] dbus_rdata_i,
  input  logic          dbus_rvalid_i
);

  localparam logic [7:0] ExeLbOp  = 8'b1110_0000;
  localparam logic [7:0] ExeLhOp  = 8'b1110_0001;
  localparam logic [7:0] ExeLwOp  = 8'b1110_0011;
  localparam logic [7:0] ExeLbuOp = 8'b1110_0100;
  localparam logic [7:0] ExeLhuOp = 8'b1110_0101;
  localparam logic [7:0] ExeSbOp  = 8'b1110_1000;
  localparam logic [7:0] ExeShOp  = 8'b1110_1001;
  localparam logic [7:0] ExeSwOp  = 8'b1110_1011;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [3:0]    be_q;
  logic [DW-1:0] wdata_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [31:0]   ld_res_q;

  logic          is_load;
  logic          is_store;
  logic          is_mem;
  logic [1:0]    size;
  logic          uns;
  logic          misaligned;
  logic          start;
  logic [3:0]    be_next;
  logic [31:0]   wdata_next;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;

  // Op decode
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = SzWord;
    uns      = 1'b0;
    case (mem_aluop_i)
      ExeLbOp:  begin is_load  = 1'b1; size = SzByte; end
      ExeLhOp:  begin is_load  = 1'b1; size = SzHalf; end
      ExeLwOp:  begin is_load  = 1'b1; size = SzWord; end
      ExeLbuOp: begin is_load  = 1'b1; size = SzByte; uns = 1'b1; end
      ExeLhuOp: begin is_load  = 1'b1; size = SzHalf; uns = 1'b1; end
      ExeSbOp:  begin is_store = 1'b1; size = SzByte; end
      ExeShOp:  begin is_store = 1'b1; size = SzHalf; end
      ExeSwOp:  begin is_store = 1'b1; size = SzWord; end
      default:  ;
    endcase
  end

  assign is_mem     = is_load | is_store;
  assign misaligned = is_mem & (((size == SzHalf) & mem_addr_i[0]) |
                                ((size == SzWord) & (mem_addr_i[1:0] != 2'b00)));
  assign start      = (state_q == StIdle) & is_mem & ~misaligned;

  // Byte enables and lane-replicated store data
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = mem_reg2_i;
    case (size)
      SzByte: begin
        be_next    = 4'b0001 << mem_addr_i[1:0];
        wdata_next = {4{mem_reg2_i[7:0]}};
      end
      SzHalf: begin
        be_next    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{mem_reg2_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select and extension
  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = dbus_rdata_i[7:0];
      2'd1:    ld_byte = dbus_rdata_i[15:8];
      2'd2:    ld_byte = dbus_rdata_i[23:16];
      default: ld_byte = dbus_rdata_i[31:24];
    endcase
    ld_half = addr_q[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
    case (size_q)
      SzByte:  ld_ext = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SzHalf:  ld_ext = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = dbus_rdata_i[31:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StReq;
      StReq:   if (dbus_gnt_i) state_d = we_q ? StDone : StWait;
      StWait:  if (dbus_rvalid_i) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= 4'b0000;
      wdata_q  <= '0;
      size_q   <= SzByte;
      uns_q    <= 1'b0;
      ld_res_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q  <= mem_addr_i[AW-1:0];
        we_q    <= is_store;
        be_q    <= be_next;
        wdata_q <= wdata_next;
        size_q  <= size;
        uns_q   <= uns;
      end
      if ((state_q == StWait) && dbus_rvalid_i) begin
        ld_res_q <= ld_ext;
      end
    end
  end

  assign dbus_req_o   = (state_q == StReq);
  assign dbus_we_o    = we_q;
  assign dbus_be_o    = be_q;
  assign dbus_addr_o  = {addr_q[AW-1:2], 2'b00};
  assign dbus_wdata_o = wdata_q;

  // Write-back is suppressed while stalled so mem/wb never sees a half-done access.
  always_comb begin
    stall_req_o = 1'b0;
    misalign_o  = 1'b0;
    wd_o        = wd_i;
    wreg_o      = wreg_i;
    wdata_o     = wdata_i;
    case (state_q)
      StIdle: begin
        if (misaligned) begin
          misalign_o = 1'b1;
          wreg_o     = 1'b0;
        end else if (is_mem) begin
          stall_req_o = 1'b1;
          wreg_o      = 1'b0;
          wdata_o     = 32'h0;
        end
      end
      StReq, StWait: begin
        stall_req_o = 1'b1;
        wreg_o      = 1'b0;
        wdata_o     = 32'h0;
      end
      default: begin
        wreg_o  = we_q ? 1'b0 : wreg_i;
        wdata_o = we_q ? 32'h0 : ld_res_q;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu with a scripted req/gnt/rvalid bus responder.
module tb_mem_lsu;

  localparam logic [7:0] OpAdd = 8'b0010_0000;
  localparam logic [7:0] OpLb  = 8'b1110_0000;
  localparam logic [7:0] OpLh  = 8'b1110_0001;
  localparam logic [7:0] OpLw  = 8'b1110_0011;
  localparam logic [7:0] OpLbu = 8'b1110_0100;
  localparam logic [7:0] OpSb  = 8'b1110_1000;
  localparam logic [7:0] OpSw  = 8'b1110_1011;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mem_aluop_i;
  logic [31:0] mem_addr_i, mem_reg2_i, wdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o, misalign_o;
  logic        dbus_req_o, dbus_we_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic        dbus_gnt_i, dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_lsu #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .mem_aluop_i(mem_aluop_i), .mem_addr_i(mem_addr_i), .mem_reg2_i(mem_reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stall_req_o(stall_req_o), .misalign_o(misalign_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_be_o(dbus_be_o),
    .dbus_addr_o(dbus_addr_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_gnt_i(dbus_gnt_i), .dbus_rdata_i(dbus_rdata_i), .dbus_rvalid_i(dbus_rvalid_i)
  );

  task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
    mem_aluop_i = op; mem_addr_i = addr; mem_reg2_i = reg2;
    wd_i = wd; wreg_i = wreg; wdata_i = wdata;
  endtask

  // Runs one access from IDLE; returns at the negedge of the first non-stalled cycle.
  task automatic do_access(input int gnt_wait, input int rv_wait, input logic [31:0] rdata,
                           output int stalls, output int reqs, output bit addr_ok,
                           output logic [31:0] a0, output logic [3:0] be0, output logic we0,
                           output logic [31:0] wd0, output bit to);
    int gnt_cyc;
    stalls = 0; reqs = 0; addr_ok = 1'b1; to = 1'b1; gnt_cyc = -1;
    a0 = '0; be0 = '0; we0 = 1'b0; wd0 = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
      if (!stall_req_o) begin
        to = 1'b0;
        break;
      end
      stalls++;
      if (dbus_req_o) begin
        reqs++;
        if (reqs == 1) begin
          a0 = dbus_addr_o; be0 = dbus_be_o; we0 = dbus_we_o; wd0 = dbus_wdata_o;
        end else if (dbus_addr_o !== a0) begin
          addr_ok = 1'b0;
        end
        if (reqs == gnt_wait + 1) begin
          dbus_gnt_i = 1'b1;
          gnt_cyc = k;
        end
      end
      if (gnt_cyc >= 0 && k - gnt_cyc == rv_wait) begin
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i = rdata;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = '0;
    set_op(OpAdd, 32'h0, 32'h0, 5'd1, 1'b1, 32'h1234);
    @(negedge clk);
    n_total++;
    if ({dbus_req_o, dbus_we_o, dbus_be_o, dbus_addr_o, dbus_wdata_o} !== '0)
      $display("FAIL reset_bus: got req=%b we=%b be=%h addr=%h wdata=%h, want all 0",
               dbus_req_o, dbus_we_o, dbus_be_o, dbus_addr_o, dbus_wdata_o);
    else n_pass++;
    n_total++;
    if (stall_req_o !== 1'b0 || wdata_o !== 32'h1234)
      $display("FAIL reset_out: got stall=%b wdata_o=%h, want 0 and 00001234",
               stall_req_o, wdata_o);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_sw;
    int st, rq; bit ok, to; logic [31:0] a, d; logic [3:0] b; logic w;
    set_op(OpSw, 32'h104, 32'hDEADBEEF, 5'd3, 1'b1, 32'h0);
    do_access(0, 0, 32'h0, st, rq, ok, a, b, w, d, to);
    n_total++;
    if (to) $display("FAIL sw_timeout: access never completed");
    else n_pass++;
    n_total++;
    if (a !== 32'h104 || b !== 4'hF || w !== 1'b1 || d !== 32'hDEADBEEF)
      $display("FAIL sw_bus: got addr=%h be=%h we=%b wdata=%h, want 00000104 f 1 deadbeef",
               a, b, w, d);
    else n_pass++;
    n_total++;
    if (st !== 2) $display("FAIL sw_stall: got %0d cycles, want 2", st);
    else n_pass++;
    n_total++;
    if (wreg_o !== 1'b0 || wdata_o !== 32'h0)
      $display("FAIL sw_done: got wreg_o=%b wdata_o=%h, want 0 0", wreg_o, wdata_o);
    else n_pass++;
    @(posedge clk); #1;
    set_op(OpAdd, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
  endtask

  task automatic test_lb(input logic [7:0] op, input logic [31:0] exp, input string nm);
    int st, rq; bit ok, to; logic [31:0] a, d; logic [3:0] b; logic w;
    set_op(op, 32'h203, 32'h0, 5'd7, 1'b1, 32'h0);
    do_access(0, 1, 32'h80FF_1234, st, rq, ok, a, b, w, d, to);
    n_total++;
    if (to || b !== 4'b1000 || w !== 1'b0 || a !== 32'h200)
      $display("FAIL %s_bus: got to=%b be=%b we=%b addr=%h, want 0 1000 0 00000200",
               nm, to, b, w, a);
    else n_pass++;
    n_total++;
    if (wdata_o !== exp || wreg_o !== 1'b1 || wd_o !== 5'd7)
      $display("FAIL %s_data: got wdata_o=%h wreg_o=%b wd_o=%0d, want %h 1 7",
               nm, wdata_o, wreg_o, wd_o, exp);
    else n_pass++;
    n_total++;
    if (st !== 3) $display("FAIL %s_stall: got %0d cycles, want 3", nm, st);
    else n_pass++;
    @(posedge clk); #1;
    set_op(OpAdd, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
  endtask

  task automatic test_lh_delayed;
    int st, rq; bit ok, to; logic [31:0] a, d; logic [3:0] b; logic w;
    set_op(OpLh, 32'h202, 32'h0, 5'd9, 1'b1, 32'h0);
    do_access(3, 2, 32'h8001_7FFF, st, rq, ok, a, b, w, d, to);
    n_total++;
    if (to || rq !== 4 || !ok || a !== 32'h200 || b !== 4'b1100)
      $display("FAIL lh_req: got to=%b req_cycles=%0d stable=%b addr=%h be=%b, want 0 4 1 200 1100",
               to, rq, ok, a, b);
    else n_pass++;
    n_total++;
    if (wdata_o !== 32'hFFFF8001) $display("FAIL lh_data: got %h, want ffff8001", wdata_o);
    else n_pass++;
    n_total++;
    if (st !== 7) $display("FAIL lh_stall: got %0d cycles, want 7", st);
    else n_pass++;
    @(posedge clk); #1;
    set_op(OpAdd, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
  endtask

  task automatic test_misalign;
    bit saw_req;
    saw_req = 1'b0;
    set_op(OpLw, 32'h102, 32'h0, 5'd4, 1'b1, 32'h0);
    @(negedge clk);
    saw_req |= dbus_req_o;
    n_total++;
    if (misalign_o !== 1'b1 || stall_req_o !== 1'b0 || wreg_o !== 1'b0)
      $display("FAIL misalign_flag: got misalign=%b stall=%b wreg_o=%b, want 1 0 0",
               misalign_o, stall_req_o, wreg_o);
    else n_pass++;
    @(posedge clk); #1;
    set_op(OpAdd, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      saw_req |= dbus_req_o;
    end
    n_total++;
    if (misalign_o !== 1'b0 || saw_req)
      $display("FAIL misalign_after: got misalign=%b saw_req=%b, want 0 0", misalign_o, saw_req);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int st, rq; bit ok, to; logic [31:0] a, d; logic [3:0] b; logic w;
    set_op(OpAdd, 32'h0, 32'h0, 5'd2, 1'b1, 32'h55);
    @(negedge clk);
    n_total++;
    if (stall_req_o !== 1'b0 || wdata_o !== 32'h55 || wreg_o !== 1'b1 || wd_o !== 5'd2)
      $display("FAIL add_pass: got stall=%b wdata_o=%h wreg_o=%b wd_o=%0d, want 0 55 1 2",
               stall_req_o, wdata_o, wreg_o, wd_o);
    else n_pass++;
    @(posedge clk); #1;
    set_op(OpSb, 32'h1, 32'hAB, 5'd0, 1'b0, 32'h0);
    do_access(0, 0, 32'h0, st, rq, ok, a, b, w, d, to);
    n_total++;
    if (to || b !== 4'b0010 || d !== 32'hABABABAB || w !== 1'b1 || st !== 2)
      $display("FAIL sb_bus: got to=%b be=%b wdata=%h we=%b stall=%0d, want 0 0010 abababab 1 2",
               to, b, d, w, st);
    else n_pass++;
    @(posedge clk); #1;
    set_op(OpAdd, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
  endtask

  task automatic test_reset_mid;
    set_op(OpLw, 32'h100, 32'h0, 5'd5, 1'b1, 32'h0);
    @(negedge clk);                       // IDLE
    @(negedge clk); dbus_gnt_i = 1'b1;    // REQ, granted
    @(negedge clk); dbus_gnt_i = 1'b0;    // WAIT
    n_total++;
    if (stall_req_o !== 1'b1 || dbus_req_o !== 1'b0)
      $display("FAIL mid_wait: got stall=%b req=%b, want 1 0", stall_req_o, dbus_req_o);
    else n_pass++;
    rst = 1'b1;
    set_op(OpAdd, 32'h0, 32'h0, 5'd6, 1'b1, 32'h77);
    #1;
    n_total++;
    if (stall_req_o !== 1'b0 || dbus_req_o !== 1'b0)
      $display("FAIL mid_async: got stall=%b req=%b, want 0 0", stall_req_o, dbus_req_o);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h1234_5678;
    @(negedge clk);
    dbus_rvalid_i = 1'b0;
    n_total++;
    if (stall_req_o !== 1'b0 || dbus_req_o !== 1'b0 || wdata_o !== 32'h77 || wreg_o !== 1'b1)
      $display("FAIL mid_after: got stall=%b req=%b wdata_o=%h wreg_o=%b, want 0 0 77 1",
               stall_req_o, dbus_req_o, wdata_o, wreg_o);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sw();
    test_lb(OpLb, 32'hFFFFFF80, "lb");
    test_lb(OpLbu, 32'h00000080, "lbu");
    test_lh_delayed();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
